serial_alu_seq: RTL and testbench

Bit-serial sequencer that runs a WIDTH-bit operation through the single-bit ALU slice (1-bit operands, carry-in, 2-bit op select, combinational Result/Cout). It accepts a parallel operand pair and op code over a ready/valid handshake and presents one bit pair per cycle to the slice, LSB first. It chains the slice's carry-out back as the next carry-in and assembles the serial result into a parallel word with carry and zero flags. It sits between the lab's control/register logic and the ALU slice, so one slice instance serves full-width operations.

---
 rtl/serial_alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_serial_alu_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer: streams a WIDTH-bit operand pair LSB-first through an
// external 1-bit ALU slice, chaining its carry, and assembles the parallel result.
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       op_i,
   input  logic             cin_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
   output logic             zero_o,
   output logic             slice_a_o,
   output logic             slice_b_o,
   output logic             slice_cin_o,
   output logic [1:0]       slice_op_o,
   input  logic             slice_result_i,
   input  logic             slice_cout_i
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [1:0]       op_r;
   logic             cin_r;
   logic             carry_r;
   logic [IW-1:0]    idx_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] result_r;
   logic             cout_r;
   logic             zero_r;
   logic             done_r;
   logic             ready_r;

   logic             last_s;
   logic [WIDTH-1:0] res_nxt_s;
   logic             slice_a_s;
   logic             slice_b_s;
   logic             slice_cin_s;

   assign last_s = (idx_r == LAST_IDX);

   // Next-state decode for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Slice pin drive; pins are quiet outside RUN so the slice sees no stray toggles.
   always_comb begin
      slice_a_s   = 1'b0;
      slice_b_s   = 1'b0;
      slice_cin_s = 1'b0;
      if (state_r == RUN) begin
         slice_a_s   = a_r[idx_r];
         slice_b_s   = b_r[idx_r];
         slice_cin_s = (idx_r == {IW{1'b0}}) ? cin_r : carry_r;
      end else begin
         slice_a_s   = 1'b0;
         slice_b_s   = 1'b0;
         slice_cin_s = 1'b0;
      end
   end

   // Current result with this cycle's slice bit merged in, so the final word is ready on the MSB edge.
   always_comb begin
      res_nxt_s = res_r;
      if (state_r == RUN) begin
         res_nxt_s[idx_r] = slice_result_i;
      end else begin
         res_nxt_s = res_r;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch, bit counter, carry chain and serial result accumulation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         op_r    <= 2'b00;
         cin_r   <= 1'b0;
         carry_r <= 1'b0;
         idx_r   <= {IW{1'b0}};
         res_r   <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  a_r     <= a_i;
                  b_r     <= b_i;
                  op_r    <= op_i;
                  cin_r   <= cin_i;
                  carry_r <= 1'b0;
                  idx_r   <= {IW{1'b0}};
                  res_r   <= {WIDTH{1'b0}};
               end else begin
                  idx_r   <= idx_r;
               end
            end
            RUN: begin
               res_r   <= res_nxt_s;
               carry_r <= slice_cout_i;
               if (!last_s) begin
                  idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
               end else begin
                  idx_r <= idx_r;
               end
            end
            default: begin
               idx_r <= idx_r;
            end
         endcase
      end
   end

   // Registered outputs: results only change on the edge that finishes the MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_r <= {WIDTH{1'b0}};
         cout_r   <= 1'b0;
         zero_r   <= 1'b0;
         done_r   <= 1'b0;
         ready_r  <= 1'b1;
      end else begin
         ready_r <= (state_nxt_s == IDLE);
         if ((state_r == RUN) && last_s) begin
            result_r <= res_nxt_s;
            cout_r   <= slice_cout_i;
            zero_r   <= (res_nxt_s == {WIDTH{1'b0}});
            done_r   <= 1'b1;
         end else begin
            done_r   <= 1'b0;
         end
      end
   end

   assign ready_o     = ready_r;
   assign done_o      = done_r;
   assign result_o    = result_r;
   assign cout_o      = cout_r;
   assign zero_o      = zero_r;
   assign slice_a_o   = slice_a_s;
   assign slice_b_o   = slice_b_s;
   assign slice_cin_o = slice_cin_s;
   assign slice_op_o  = op_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit ALU slice attached.
module tb_serial_alu_seq;

   logic       clk;
   logic       rst_n;
   logic       start_i;
   logic       ready_o;
   logic [7:0] a_i;
   logic [7:0] b_i;
   logic [1:0] op_i;
   logic       cin_i;
   logic       done_o;
   logic [7:0] result_o;
   logic       cout_o;
   logic       zero_o;
   logic       slice_a_o;
   logic       slice_b_o;
   logic       slice_cin_o;
   logic [1:0] slice_op_o;
   logic       slice_result_i;
   logic       slice_cout_i;

   int checks;
   int errors;

   serial_alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_o(ready_o),
      .a_i(a_i), .b_i(b_i), .op_i(op_i), .cin_i(cin_i),
      .done_o(done_o), .result_o(result_o), .cout_o(cout_o), .zero_o(zero_o),
      .slice_a_o(slice_a_o), .slice_b_o(slice_b_o), .slice_cin_o(slice_cin_o),
      .slice_op_o(slice_op_o), .slice_result_i(slice_result_i), .slice_cout_i(slice_cout_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slice model: full-adder carry is always produced; op 00 is taken as OR.
   always_comb begin
      case (slice_op_o)
         2'b01:   slice_result_i = slice_a_o ^ slice_b_o ^ slice_cin_o;
         2'b10:   slice_result_i = slice_a_o & slice_b_o;
         2'b11:   slice_result_i = ~slice_a_o;
         default: slice_result_i = slice_a_o | slice_b_o;
      endcase
      slice_cout_i = (slice_a_o & slice_b_o) | (slice_cin_o & (slice_a_o ^ slice_b_o));
   end

   // Issue one request once ready, return cycles from accept to done (-1 on timeout).
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic cin, output int lat);
      lat = -1;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (ready_o) break;
      end
      a_i = a; b_i = b; op_i = op; cin_i = cin; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done_o) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; op_i = 2'b00; cin_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
      checks++; if (result_o !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", result_o); end
      checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout_o); end
      checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero_o); end
      checks++; if ({slice_a_o, slice_b_o, slice_cin_o, slice_op_o} !== 5'b00000) begin
         errors++; $display("FAIL reset_slice got %b exp 00000", {slice_a_o, slice_b_o, slice_cin_o, slice_op_o});
      end
   endtask

   task automatic test_add;
      int lat;
      do_op(8'h5A, 8'h3C, 2'b01, 1'b0, lat);
      checks++; if (lat != 9) begin errors++; $display("FAIL add_latency got %0d exp 9", lat); end
      checks++; if (result_o !== 8'h96) begin errors++; $display("FAIL add_result got %h exp 96", result_o); end
      checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL add_cout got %b exp 0", cout_o); end
      checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", zero_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL add_ready_in_done got %b exp 0", ready_o); end
      @(negedge clk);
      checks++; if (ready_o !== 1'b1 || done_o !== 1'b0 || result_o !== 8'h96) begin
         errors++; $display("FAIL add_hold got ready %b done %b result %h exp 1 0 96", ready_o, done_o, result_o);
      end
   endtask

   task automatic test_carry;
      int lat;
      do_op(8'hFF, 8'h01, 2'b01, 1'b0, lat);
      checks++; if (lat != 9) begin errors++; $display("FAIL ripple_latency got %0d exp 9", lat); end
      checks++; if (result_o !== 8'h00) begin errors++; $display("FAIL ripple_result got %h exp 00", result_o); end
      checks++; if (cout_o !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b exp 1", cout_o); end
      checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL ripple_zero got %b exp 1", zero_o); end
      do_op(8'h00, 8'h00, 2'b01, 1'b1, lat);
      checks++; if (result_o !== 8'h01) begin errors++; $display("FAIL cin_result got %h exp 01", result_o); end
      checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL cin_cout got %b exp 0", cout_o); end
      checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL cin_zero got %b exp 0", zero_o); end
   endtask

   // Watches the slice pins bit by bit while a logic op runs.
   task automatic run_logic(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                            input logic [7:0] exp);
      int lat;
      int bad_op;
      int bad_bit;
      lat = -1; bad_op = 0; bad_bit = 0;
      @(negedge clk);
      a_i = a; b_i = b; op_i = op; cin_i = 1'b0; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0; a_i = ~a; op_i = ~op;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k <= 8) begin
            if (slice_op_o !== op || ready_o !== 1'b0) bad_op++;
            if (slice_a_o !== a[k-1] || slice_b_o !== b[k-1]) bad_bit++;
         end
         if (done_o) begin
            lat = k;
            break;
         end
      end
      checks++; if (bad_op != 0) begin errors++; $display("FAIL logic_op_hold op %b bad cycles %0d exp 0", op, bad_op); end
      checks++; if (bad_bit != 0) begin errors++; $display("FAIL logic_bit_order op %b bad cycles %0d exp 0", op, bad_bit); end
      checks++; if (lat != 9) begin errors++; $display("FAIL logic_latency got %0d exp 9", lat); end
      checks++; if (result_o !== exp) begin errors++; $display("FAIL logic_result op %b got %h exp %h", op, result_o, exp); end
   endtask

   task automatic test_logic;
      run_logic(8'hF0, 8'h3C, 2'b10, 8'h30);
      run_logic(8'hF0, 8'h3C, 2'b11, 8'h0F);
      run_logic(8'hA0, 8'h05, 2'b00, 8'hA5);
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_q[$];
      int   acc_cyc[$];
      int   dones;
      int   last_acc;
      logic rdy;
      logic [7:0] av;
      logic [7:0] bv;
      logic [7:0] ev;
      dones = 0; last_acc = -100;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (ready_o) break;
      end
      for (int c = 0; c < 30; c++) begin
         if (c > 0) @(negedge clk);
         if (done_o) begin
            dones++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++; if (result_o !== ev) begin errors++; $display("FAIL b2b_result got %h exp %h", result_o, ev); end
         end
         if (c - last_acc >= 1 && c - last_acc <= 9) begin
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready cycle %0d got %b exp 0", c, ready_o); end
         end
         av = 8'(c * 7 + 3);
         bv = 8'(c * 13 + 1);
         a_i = av; b_i = bv; op_i = 2'b01; cin_i = 1'b0; start_i = 1'b1;
         rdy = ready_o;
         @(posedge clk);
         if (rdy) begin
            acc_cyc.push_back(c);
            exp_q.push_back(av + bv);
            last_acc = c;
         end
      end
      #1 start_i = 1'b0;
      checks++; if (acc_cyc.size() != 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", acc_cyc.size()); end
      checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones got %0d exp 3", dones); end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         checks++; if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
            errors++; $display("FAIL b2b_spacing got %0d exp 10", acc_cyc[i] - acc_cyc[i-1]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      int seen_done;
      seen_done = 0;
      @(negedge clk);
      a_i = 8'h5A; b_i = 8'h3C; op_i = 2'b01; cin_i = 1'b0; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (done_o) seen_done++;
         checks++; if (result_o !== 8'h00) begin errors++; $display("FAIL midreset_result got %h exp 00", result_o); end
         @(negedge clk);
      end
      checks++; if (seen_done != 0) begin errors++; $display("FAIL midreset_done got %0d pulses exp 0", seen_done); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", ready_o); end
      // Reset and start at the same edge: the request must be dropped.
      rst_n = 1'b0; start_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1; start_i = 1'b0;
      @(negedge clk);
      checks++; if (ready_o !== 1'b1 || slice_a_o !== 1'b0) begin
         errors++; $display("FAIL reset_wins got ready %b slice_a %b exp 1 0", ready_o, slice_a_o);
      end
      do_op(8'h01, 8'h02, 2'b01, 1'b0, lat);
      checks++; if (lat != 9) begin errors++; $display("FAIL post_reset_latency got %0d exp 9", lat); end
      checks++; if (result_o !== 8'h03) begin errors++; $display("FAIL post_reset_result got %h exp 03", result_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_carry();
      test_logic();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
